sopc_run_ctrl: RTL and testbench



---
 rtl/sopc_run_ctrl_if.sv | 18 +
 rtl/sopc_run_ctrl.sv | 159 +++++++++++++++
 tb/tb_sopc_run_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sopc_run_ctrl_if.sv
// sopc_run_ctrl_if
//   Write-back snoop bus between the CPU core and the run controller.
//   The controller only observes these signals; it never drives them.
//   Signals:
//     wb_wreg  - write-back register write enable
//     wb_wd    - write-back destination GPR index
//     wb_wdata - write-back data
//   Modports:
//     master - CPU side (drives the write-back fields)
//     slave  - controller side (observes the write-back fields)
interface sopc_run_ctrl_if;
  logic        wb_wreg;
  logic [4:0]  wb_wd;
  logic [31:0] wb_wdata;

  modport master (output wb_wreg, output wb_wd, output wb_wdata);
  modport slave  (input  wb_wreg, input  wb_wd, input  wb_wdata);
endinterface

// File: rtl/sopc_run_ctrl.sv
// sopc_run_ctrl
//   Reset and run controller for mips_min_sopc on the board. Turns the
//   board's asynchronous active-low reset into a held, synchronously
//   released, active-high CPU reset; counts run cycles; freezes the CPU
//   when the CPU writes the sentinel value to the sentinel register.
//   Optional feature macro: SOPC_RUN_TIMEOUT_EN -- when defined, the CPU
//   is also frozen once run_cycles reaches RUN_LIMIT.
//   Ports:
//     clk        - system clock, rising edge
//     rst        - asynchronous active-low board reset
//     start      - restart request, honoured only while halted
//     wb         - write-back snoop bus (slave modport)
//     cpu_rst    - active-high reset to mips_min_sopc.rst
//     running    - high while the CPU is running
//     halted     - high while the CPU is frozen
//     halt_cause - 00 none, 01 sentinel, 10 timeout
//     run_cycles - cycles spent running since the last hold (saturating)
module sopc_run_ctrl #(
  parameter int unsigned HOLD_CYCLES = 10,
  parameter int unsigned RUN_LIMIT   = 100,
  parameter logic [4:0]  HALT_REG    = 5'd31,
  parameter logic [31:0] HALT_VAL    = 32'hDEAD_BEEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  sopc_run_ctrl_if.slave       wb,
  output logic                 cpu_rst,
  output logic                 running,
  output logic                 halted,
  output logic [1:0]           halt_cause,
  output logic [31:0]          run_cycles
);

  localparam int unsigned HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_SENTINEL = 2'b01,
    CAUSE_TIMEOUT  = 2'b10
  } cause_e;

  state_e         state_q, state_d;
  cause_e         cause_q, cause_d;
  logic [1:0]     sync_q, sync_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic [31:0]    run_cycles_q, run_cycles_d;
  logic           cpu_rst_q, cpu_rst_d;
  logic           running_q, running_d;
  logic           halted_q, halted_d;

  logic           rst_sync;
  logic           sentinel;
  logic           timeout;

  assign rst_sync = sync_q[1];
  assign sentinel = wb.wb_wreg && (wb.wb_wd == HALT_REG) && (wb.wb_wdata == HALT_VAL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_HOLD;
      cause_q      <= CAUSE_NONE;
      sync_q       <= '0;
      hold_cnt_q   <= '0;
      run_cycles_q <= '0;
      cpu_rst_q    <= 1'b1;
      running_q    <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      sync_q       <= sync_d;
      hold_cnt_q   <= hold_cnt_d;
      run_cycles_q <= run_cycles_d;
      cpu_rst_q    <= cpu_rst_d;
      running_q    <= running_d;
      halted_q     <= halted_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    sync_d       = {sync_q[0], 1'b1};
    hold_cnt_d   = hold_cnt_q;
    run_cycles_d = run_cycles_q;
    timeout      = 1'b0;

    case (state_q)
      ST_HOLD: begin
        // The hold count only starts once the released reset has passed
        // through both synchronizer stages.
        if (rst_sync) begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d    = ST_RUN;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HCW'(1);
          end
        end
      end

      ST_RUN: begin
        if (run_cycles_q != '1) begin
          run_cycles_d = run_cycles_q + 32'd1;
        end
`ifdef SOPC_RUN_TIMEOUT_EN
        timeout = (run_cycles_d == RUN_LIMIT);
`endif
        // Sentinel takes priority when both fire on the same edge.
        if (sentinel) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_SENTINEL;
        end else if (timeout) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_TIMEOUT;
        end
      end

      ST_HALTED: begin
        if (start) begin
          state_d      = ST_HOLD;
          hold_cnt_d   = '0;
          run_cycles_d = '0;
          cause_d      = CAUSE_NONE;
        end
      end

      default: begin
        state_d = ST_HOLD;
      end
    endcase

    // Outputs are flopped from the next state so every output is a
    // register with no combinational path from the inputs.
    cpu_rst_d = (state_d != ST_RUN);
    running_d = (state_d == ST_RUN);
    halted_d  = (state_d == ST_HALTED);
  end

`ifndef SOPC_RUN_TIMEOUT_EN
  logic unused_run_limit;
  assign unused_run_limit = ^RUN_LIMIT;
`endif

  assign cpu_rst    = cpu_rst_q;
  assign running    = running_q;
  assign halted     = halted_q;
  assign halt_cause = cause_q;
  assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// tb_sopc_run_ctrl
//   Randomized self-checking bench for sopc_run_ctrl. The reference model
//   tracks a countdown of edges until the CPU runs, a running/halted flag
//   pair and a saturating cycle count, updated once per rising edge.
module tb_sopc_run_ctrl;

  localparam int unsigned HOLD  = 10;
  localparam int unsigned LIMIT = 100;
  localparam logic [4:0]  HREG  = 5'd31;
  localparam logic [31:0] HVAL  = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        start;
  logic        cpu_rst;
  logic        running;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [31:0] run_cycles;

  sopc_run_ctrl_if wb_if ();

  sopc_run_ctrl #(
    .HOLD_CYCLES (HOLD),
    .RUN_LIMIT   (LIMIT),
    .HALT_REG    (HREG),
    .HALT_VAL    (HVAL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .wb         (wb_if),
    .cpu_rst    (cpu_rst),
    .running    (running),
    .halted     (halted),
    .halt_cause (halt_cause),
    .run_cycles (run_cycles)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit          m_running;
  bit          m_halted;
  int          m_countdown;
  bit [31:0]   m_cycles;
  bit [1:0]    m_cause;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_running   = 1'b0;
    m_halted    = 1'b0;
    m_countdown = int'(HOLD) + 2;
    m_cycles    = '0;
    m_cause     = 2'b00;
  endtask

  task automatic model_edge();
    bit sent;
    bit tmo;
    sent = wb_if.wb_wreg && (wb_if.wb_wd == HREG) && (wb_if.wb_wdata == HVAL);
    if (m_halted) begin
      if (start) begin
        m_halted    = 1'b0;
        m_countdown = int'(HOLD);
        m_cycles    = '0;
        m_cause     = 2'b00;
      end
    end else if (m_running) begin
      if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
`ifdef SOPC_RUN_TIMEOUT_EN
      tmo = (m_cycles == LIMIT);
`else
      tmo = 1'b0;
`endif
      if (sent) begin
        m_running = 1'b0; m_halted = 1'b1; m_cause = 2'b01;
      end else if (tmo) begin
        m_running = 1'b0; m_halted = 1'b1; m_cause = 2'b10;
      end
    end else begin
      m_countdown--;
      if (m_countdown == 0) m_running = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("cpu_rst",    cpu_rst,    !m_running);
    check("running",    running,    m_running);
    check("halted",     halted,     m_halted);
    check("halt_cause", halt_cause, m_cause);
    check("run_cycles", run_cycles, m_cycles);
  endtask

  // Drive inputs (just after a falling edge), take one rising edge,
  // update the model, then compare on the following falling edge.
  task automatic cycle(input bit st, input bit wreg, input logic [4:0] wd, input logic [31:0] wdata);
    start          = st;
    wb_if.wb_wreg  = wreg;
    wb_if.wb_wd    = wd;
    wb_if.wb_wdata = wdata;
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic noise(input bit st);
    logic [4:0]  wd;
    logic [31:0] wdata;
    wd    = 5'($urandom);
    wdata = $urandom;
    if (wdata == HVAL) wdata = ~wdata;
    cycle(st, 1'($urandom), wd, wdata);
  endtask

  // Walk through a hold sequence of n edges; optionally poke start.
  task automatic hold_seq(input int n, input bit poke_start, input string tag);
    for (int i = 1; i < n; i++) begin
      cycle(poke_start && (i % 3 == 1), 1'b0, 5'd0, 32'd0);
    end
    check({tag, "_pre_cpu_rst"}, cpu_rst, 1'b1);
    idle();
    check({tag, "_cpu_rst_low"}, cpu_rst, 1'b0);
    check({tag, "_running"}, running, 1'b1);
  endtask

  task automatic run_until(input int target, input string tag);
    int guard;
    guard = 0;
    while (m_cycles < 32'(target) && m_running && guard < 1000) begin
      idle();
      guard++;
    end
    check({tag, "_reached"}, m_cycles, 32'(target));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst            = 1'b0;
    start          = 1'b0;
    wb_if.wb_wreg  = 1'b0;
    wb_if.wb_wd    = '0;
    wb_if.wb_wdata = '0;
    model_reset();

    #100;
    check("rst_cpu_rst", cpu_rst, 1'b1);
    check("rst_running", running, 1'b0);
    check("rst_halted",  halted,  1'b0);
    check("rst_cause",   halt_cause, 2'b00);
    check("rst_cycles",  run_cycles, 32'd0);

    // Release between edges; next rising edge is edge 1 after release.
    #95;
    rst = 1'b1;
    @(negedge clk);
    hold_seq(int'(HOLD) + 2, 1'b1, "hold");

    // RUN with stray start pulses and non-matching write-back traffic.
    guard = 0;
    while (m_cycles < 37 && guard < 200) begin
      noise($urandom_range(0, 3) == 0);
      guard++;
    end
    check("pre_arst_cycles", run_cycles, 32'd37);
    check("pre_arst_running", running, 1'b1);

    // Asynchronous reset mid-RUN, between edges.
    #5;
    rst = 1'b0;
    #1;
    model_reset();
    check("arst_cpu_rst", cpu_rst, 1'b1);
    check("arst_running", running, 1'b0);
    check("arst_cycles",  run_cycles, 32'd0);
    check("arst_halted",  halted, 1'b0);
    @(negedge clk);
    idle();
    idle();
    rst = 1'b1;
    hold_seq(int'(HOLD) + 2, 1'b0, "rehold");

    // Near-miss sentinel writes must not halt.
    cycle(1'b0, 1'b1, 5'd30, 32'hDEAD_BEEF);
    check("near_reg_running", running, 1'b1);
    cycle(1'b0, 1'b1, 5'd31, 32'hDEAD_BEEE);
    check("near_val_running", running, 1'b1);
    cycle(1'b0, 1'b0, 5'd31, 32'hDEAD_BEEF);
    check("near_wen_running", running, 1'b1);

    // Sentinel on RUN edge 20.
    run_until(19, "sent19");
    cycle(1'b0, 1'b1, HREG, HVAL);
    check("sent_halted",  halted, 1'b1);
    check("sent_cause",   halt_cause, 2'b01);
    check("sent_cpu_rst", cpu_rst, 1'b1);
    check("sent_cycles",  run_cycles, 32'd20);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) cycle(1'b0, 1'b1, HREG, HVAL);
      else noise(1'b0);
    end
    check("halt_hold_cycles", run_cycles, 32'd20);
    check("halt_hold_cause",  halt_cause, 2'b01);

    // Restart from HALTED.
    cycle(1'b1, 1'b0, 5'd0, 32'd0);
    check("restart_cycles",  run_cycles, 32'd0);
    check("restart_cause",   halt_cause, 2'b00);
    check("restart_cpu_rst", cpu_rst, 1'b1);
    hold_seq(int'(HOLD), 1'b1, "restart");

`ifdef SOPC_RUN_TIMEOUT_EN
    guard = 0;
    while (!halted && guard < 300) begin
      idle();
      guard++;
    end
    check("tmo_halted", halted, 1'b1);
    check("tmo_cause",  halt_cause, 2'b10);
    check("tmo_cycles", run_cycles, LIMIT);
    cycle(1'b1, 1'b0, 5'd0, 32'd0);
    hold_seq(int'(HOLD), 1'b0, "tmo_restart");
    run_until(int'(LIMIT) - 1, "tie99");
    cycle(1'b0, 1'b1, HREG, HVAL);
    check("tie_cause",  halt_cause, 2'b01);
    check("tie_cycles", run_cycles, LIMIT);
`else
    for (int i = 0; i < 150; i++) idle();
    check("notmo_running", running, 1'b1);
    check("notmo_cause",   halt_cause, 2'b00);
    check("notmo_cycles",  run_cycles, 32'd150);
    cycle(1'b0, 1'b1, HREG, HVAL);
    check("notmo_sent_cause", halt_cause, 2'b01);
`endif

    // Free-running randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0)
        cycle($urandom_range(0, 9) == 0, 1'b1, HREG, HVAL);
      else
        noise($urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
